product_serializer: RTL and testbench

//  Downstream stage of the signed multiplier: captures each finished 24-bit signed product
//  on the multiplier's done pulse and shifts it out serially on z_out under sz control.
//  A one-deep hold register accepts the next product while a frame is still shifting.
//  fz marks the last bit of each frame, and a sticky ovf flags lost products.

---
 rtl/product_serializer.sv | 155 +++++++++++++++
 tb/tb_product_serializer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/product_serializer.sv
// Serializes captured signed products onto z_out with a one-deep hold register,
// a last-bit marker (fz) and sticky overflow. Optional parity bit: PRODUCT_SERIALIZER_PARITY_EN.
module product_serializer #(
  parameter int unsigned WIDTH     = 24,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] z_parallel,
  input  logic             sz,
  output logic             z_out,
  output logic             fz,
  output logic             busy,
  output logic             pending,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef PRODUCT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t             state, state_d;
  logic [WIDTH-1:0]   shreg, shreg_d;
  logic [WIDTH-1:0]   hold, hold_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               pending_d, ovf_d, z_d, fz_d, busy_d;
  logic               next_bit;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
  logic               par, par_d;
`endif

  assign next_bit = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      hold    <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      ovf     <= 1'b0;
      z_out   <= 1'b0;
      fz      <= 1'b0;
      busy    <= 1'b0;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      hold    <= hold_d;
      cnt     <= cnt_d;
      pending <= pending_d;
      ovf     <= ovf_d;
      z_out   <= z_d;
      fz      <= fz_d;
      busy    <= busy_d;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
      par     <= par_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    hold_d    = hold;
    cnt_d     = cnt;
    pending_d = pending;
    ovf_d     = ovf;
    z_d       = z_out;
    fz_d      = fz;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
    par_d     = par;
`endif

    case (state)
      IDLE: begin
        if (pending) begin
          shreg_d   = hold;
          pending_d = 1'b0;
          state_d   = SHIFT;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
          par_d     = 1'b0;
`endif
        end else if (load) begin
          shreg_d = z_parallel;
          state_d = SHIFT;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        fz_d = 1'b0;
        if (sz) begin
          z_d     = next_bit;
          shreg_d = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
          cnt_d   = cnt + CNT_W'(1);
`ifdef PRODUCT_SERIALIZER_PARITY_EN
          par_d   = par ^ next_bit;
          if (cnt == CNT_W'(WIDTH - 1)) state_d = PARITY;
`else
          if (cnt == CNT_W'(WIDTH - 1)) begin
            fz_d    = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
`ifdef PRODUCT_SERIALIZER_PARITY_EN
      PARITY: begin
        fz_d = 1'b0;
        if (sz) begin
          z_d     = par;
          fz_d    = 1'b1;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        z_d     = 1'b0;
        fz_d    = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A load not consumed directly by IDLE goes to the hold register, or is dropped
    if (load) begin
      if (state == IDLE) begin
        if (pending) begin
          hold_d    = z_parallel;
          pending_d = 1'b1;
        end
      end else if (!pending) begin
        hold_d    = z_parallel;
        pending_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_product_serializer.sv
// Directed self-checking bench for product_serializer (LSB first, WIDTH 24).
`timescale 1ns/1ps
module tb_product_serializer;

  localparam int unsigned W = 24;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst, load, sz;
  logic [W-1:0] z_parallel;
  logic         z_out, fz, busy, pending, ovf;

  int pass_cnt = 0;
  int total    = 0;

  product_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .z_parallel(z_parallel), .sz(sz),
    .z_out(z_out), .fz(fz), .busy(busy), .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps n cycles, collecting z_out in order; load is treated as a one-cycle pulse
  task automatic shift_frame(input int n, output logic [31:0] d, output int fzc, output logic fzl);
    d = '0; fzc = 0; fzl = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      load = 1'b0;
      d[k] = z_out;
      if (fz) fzc++;
      fzl = fz;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; sz = 1'b1; z_parallel = '0;
    step(); step();
    total++; if ({z_out, fz, busy, pending, ovf} !== 5'b0)
      $display("FAIL reset_outputs: got %b required 00000", {z_out, fz, busy, pending, ovf});
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] d; int fzc; logic fzl; logic [24:0] exp_f;
    exp_f = {1'b0, 24'hA5A5A5};
    z_parallel = 24'hA5A5A5; load = 1'b1; sz = 1'b1;
    step(); load = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL basic_busy_rise: got %b required 1", busy); else pass_cnt++;
    shift_frame(FL, d, fzc, fzl);
    total++; if (d[FL-1:0] !== exp_f[FL-1:0])
      $display("FAIL basic_frame: got %h required %h", d[FL-1:0], exp_f[FL-1:0]);
    else pass_cnt++;
    total++; if (fzc !== 1 || fzl !== 1'b1)
      $display("FAIL basic_fz: got count %0d last %b required 1 1", fzc, fzl);
    else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL basic_busy_done: got %b required 1", busy); else pass_cnt++;
    step();
    total++; if (z_out !== 1'b0 || fz !== 1'b0)
      $display("FAIL basic_after_done: got z %b fz %b required 0 0", z_out, fz);
    else pass_cnt++;
    step();
    total++; if (busy !== 1'b0) $display("FAIL basic_busy_fall: got %b required 0", busy); else pass_cnt++;
  endtask

  task automatic test_stall();
    logic [31:0] d1, d2, full; int fzc1, fzc2; logic fzl1, fzl2; logic [24:0] exp_f;
    int held;
    exp_f = {1'b0, 24'hA5A5A5};
    z_parallel = 24'hA5A5A5; load = 1'b1; sz = 1'b1;
    step(); load = 1'b0;
    shift_frame(10, d1, fzc1, fzl1);
    sz = 1'b0; held = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (z_out === 1'b0 && fz === 1'b0) held++;
    end
    sz = 1'b1;
    total++; if (held !== 5) $display("FAIL stall_hold_bit9: got %0d held cycles required 5", held); else pass_cnt++;
    shift_frame(FL - 10, d2, fzc2, fzl2);
    full = {22'b0, d1[9:0]} | (d2 << 10);
    total++; if (full[FL-1:0] !== exp_f[FL-1:0])
      $display("FAIL stall_frame: got %h required %h", full[FL-1:0], exp_f[FL-1:0]);
    else pass_cnt++;
    total++; if (fzc1 + fzc2 !== 1 || fzl2 !== 1'b1)
      $display("FAIL stall_fz: got count %0d last %b required 1 1", fzc1 + fzc2, fzl2);
    else pass_cnt++;
    step(); step();
  endtask

  task automatic test_pending();
    logic [31:0] d1, d2, full; int fzc1, fzc2; logic fzl1, fzl2; logic [24:0] e1, e2;
    e1 = {1'b1, 24'h000001}; e2 = {1'b1, 24'h800000};
    z_parallel = 24'h000001; load = 1'b1;
    step(); load = 1'b0;
    shift_frame(4, d1, fzc1, fzl1);
    z_parallel = 24'h800000; load = 1'b1;
    shift_frame(FL - 4, d2, fzc2, fzl2);
    full = {28'b0, d1[3:0]} | (d2 << 4);
    total++; if (full[FL-1:0] !== e1[FL-1:0])
      $display("FAIL pending_first_frame: got %h required %h", full[FL-1:0], e1[FL-1:0]);
    else pass_cnt++;
    total++; if (pending !== 1'b1) $display("FAIL pending_set: got %b required 1", pending); else pass_cnt++;
    step(); step();
    total++; if (busy !== 1'b1 || pending !== 1'b0)
      $display("FAIL pending_restart: got busy %b pending %b required 1 0", busy, pending);
    else pass_cnt++;
    shift_frame(FL, d1, fzc1, fzl1);
    total++; if (d1[FL-1:0] !== e2[FL-1:0] || d1[23] !== 1'b1)
      $display("FAIL pending_second_frame: got %h required %h", d1[FL-1:0], e2[FL-1:0]);
    else pass_cnt++;
    total++; if (fzc1 !== 1 || fzl1 !== 1'b1)
      $display("FAIL pending_second_fz: got count %0d last %b required 1 1", fzc1, fzl1);
    else pass_cnt++;
    step(); step();
  endtask

  task automatic test_overflow();
    logic [31:0] d1, d2, d3, full; int c1, c2, c3; logic l1, l2, l3; logic [24:0] e1, e2;
    int idle_ok;
    e1 = {1'b0, 24'h111111}; e2 = {1'b0, 24'h222222};
    total++; if (ovf !== 1'b0) $display("FAIL ovf_clear_before: got %b required 0", ovf); else pass_cnt++;
    z_parallel = 24'h111111; load = 1'b1;
    step(); load = 1'b0;
    shift_frame(3, d1, c1, l1);
    z_parallel = 24'h222222; load = 1'b1;
    shift_frame(3, d2, c2, l2);
    z_parallel = 24'h333333; load = 1'b1;
    shift_frame(FL - 6, d3, c3, l3);
    full = {29'b0, d1[2:0]} | {26'b0, d2[2:0], 3'b0} | (d3 << 6);
    total++; if (full[FL-1:0] !== e1[FL-1:0])
      $display("FAIL ovf_first_frame: got %h required %h", full[FL-1:0], e1[FL-1:0]);
    else pass_cnt++;
    total++; if (ovf !== 1'b1 || pending !== 1'b1)
      $display("FAIL ovf_set: got ovf %b pending %b required 1 1", ovf, pending);
    else pass_cnt++;
    step(); step();
    shift_frame(FL, d1, c1, l1);
    total++; if (d1[FL-1:0] !== e2[FL-1:0])
      $display("FAIL ovf_held_frame: got %h required %h", d1[FL-1:0], e2[FL-1:0]);
    else pass_cnt++;
    idle_ok = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (busy === 1'b0 && pending === 1'b0 && z_out === 1'b0) idle_ok++;
    end
    total++; if (idle_ok !== 4 || ovf !== 1'b1)
      $display("FAIL ovf_dropped_not_sent: got idle %0d ovf %b required 4 1", idle_ok, ovf);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d; int c; logic l; logic [24:0] e;
    e = {1'b0, 24'hFFFFFF};
    z_parallel = 24'hA5A5A5; load = 1'b1;
    step(); load = 1'b0;
    shift_frame(3, d, c, l);
    z_parallel = 24'h123456; load = 1'b1;
    shift_frame(8, d, c, l);
    total++; if (z_out !== 1'b1 || pending !== 1'b1)
      $display("FAIL midrst_bit10: got z %b pending %b required 1 1", z_out, pending);
    else pass_cnt++;
    rst = 1'b1;
    step(); rst = 1'b0;
    total++; if ({z_out, fz, busy, pending, ovf} !== 5'b0)
      $display("FAIL midrst_outputs: got %b required 00000", {z_out, fz, busy, pending, ovf});
    else pass_cnt++;
    z_parallel = 24'hFFFFFF; load = 1'b1;
    step(); load = 1'b0;
    shift_frame(FL, d, c, l);
    total++; if (d[FL-1:0] !== e[FL-1:0] || c !== 1 || l !== 1'b1)
      $display("FAIL midrst_ones_frame: got %h fz %0d required %h fz 1", d[FL-1:0], c, e[FL-1:0]);
    else pass_cnt++;
    step(); step();
  endtask

  task automatic test_parity();
    logic [31:0] d; int c; logic l; logic [24:0] e7, e0;
    e7 = {1'b1, 24'h000007}; e0 = {1'b0, 24'h000000};
    z_parallel = 24'h000007; load = 1'b1;
    step(); load = 1'b0;
    shift_frame(FL, d, c, l);
    total++; if (d[FL-1:0] !== e7[FL-1:0] || c !== 1 || l !== 1'b1)
      $display("FAIL parity_7: got %h fz %0d last %b required %h fz 1 1", d[FL-1:0], c, l, e7[FL-1:0]);
    else pass_cnt++;
    step(); step();
    z_parallel = 24'h000000; load = 1'b1;
    step(); load = 1'b0;
    shift_frame(FL, d, c, l);
    total++; if (d[FL-1:0] !== e0[FL-1:0] || c !== 1 || l !== 1'b1)
      $display("FAIL parity_0: got %h fz %0d last %b required %h fz 1 1", d[FL-1:0], c, l, e0[FL-1:0]);
    else pass_cnt++;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_pending();
    test_overflow();
    test_reset_mid_frame();
    test_parity();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
